// File: rtl/smg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : smg_scan_ctrl
//  Purpose  : Multiplexed seven-segment scan controller with register port,
//             hex/raw decode, 16-level PWM brightness, blank mask and
//             frame-synchronous double buffering of display registers.
//  Options  : SMG_BLINK_EN - adds per-digit blink mask and frame-based blink.
//  Revision : 1.0 - initial release
// ============================================================================
module smg_scan_ctrl #(
  parameter int NUM_DIGITS      = 6,
  parameter int SUB_DIV         = 1024,
  parameter int AW              = 5,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SCAN_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES    = 64
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [7:0]            SMG_Data,
  output logic [NUM_DIGITS-1:0] Scan_Sig,
  output logic                  frame_tick
);

  localparam int PW = $clog2(16 * SUB_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(16 * SUB_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SCAN_OFF = SCAN_ACTIVE_LOW ? '1 : '0;
  localparam logic [0:0] ST_OFF  = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  raw_q;
  logic [3:0]            bright_q;
  logic [NUM_DIGITS-1:0] blank_sh_q, blank_act_q;
  logic [7:0]            digit_sh_q  [NUM_DIGITS];
  logic [7:0]            digit_act_q [NUM_DIGITS];
  logic                  pending_q;
  logic [PW-1:0]         pcnt_q;
  logic [DW-1:0]         dig_q;
  logic                  ft_q;

  logic                  w_wr_ctrl, w_wr_blank, w_wr_shadow;
  logic [NUM_DIGITS-1:0] w_wr_digit;
  logic                  w_run, w_lit, w_frame_end, w_commit, w_track;
  logic                  w_blink_dark;
  logic [3:0]            w_sub;
  logic [7:0]            w_cur, w_seg;
  logic [31:0]           w_rdata;
  logic                  w_unused_wr;

  assign w_unused_wr = ^wr_data;
  assign w_track     = (state_q == ST_OFF);
  assign w_commit    = ft_q && pending_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h3F;  4'h1: r = 7'h06;  4'h2: r = 7'h5B;  4'h3: r = 7'h4F;
      4'h4: r = 7'h66;  4'h5: r = 7'h6D;  4'h6: r = 7'h7D;  4'h7: r = 7'h07;
      4'h8: r = 7'h7F;  4'h9: r = 7'h6F;  4'hA: r = 7'h77;  4'hB: r = 7'h7C;
      4'hC: r = 7'h39;  4'hD: r = 7'h5E;  4'hE: r = 7'h79;  default: r = 7'h71;
    endcase
    return r;
  endfunction

`ifdef SMG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] blink_sh_q, blink_act_q;
  logic [FW-1:0]         fcnt_q;
  logic                  phase_q;
  logic                  w_wr_blink;

  assign w_wr_blink   = wr_en && (wr_addr == AW'(2));
  assign w_blink_dark = phase_q && blink_act_q[dig_q];

  // Blink mask shadow/active copies follow the same commit rules as BLANK
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      blink_sh_q  <= '0;
      blink_act_q <= '0;
    end else begin
      if (w_wr_blink) blink_sh_q <= wr_data[NUM_DIGITS-1:0];
      if (w_track || w_commit) blink_act_q <= blink_sh_q;
    end
  end

  // Frame counter toggles blink phase every BLINK_FRAMES frames; idle when off
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || !w_run) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (w_frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = 32'(BLINK_FRAMES);
  assign w_blink_dark = 1'b0;
`endif

  // Write address decode; any shadow write marks the display as pending
  always_comb begin
    w_wr_ctrl  = wr_en && (wr_addr == AW'(0));
    w_wr_blank = wr_en && (wr_addr == AW'(1));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_wr_digit[i] = wr_en && (wr_addr == AW'(4 + i));
    end
    w_wr_shadow = w_wr_blank || (|w_wr_digit);
`ifdef SMG_BLINK_EN
    w_wr_shadow = w_wr_shadow || w_wr_blink;
`endif
  end

  // FSM state register: OFF while disabled, SCAN while enabled
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= ST_OFF;
    else              state_q <= state_d;
  end

  // FSM next state: the CTRL enable bit is the only transition source
  always_comb begin
    state_d = state_q;
    if (w_wr_ctrl) state_d = wr_data[0] ? ST_SCAN : ST_OFF;
  end

  // FSM outputs: sub-phase, lit decision, segment pattern, frame end
  always_comb begin
    w_run       = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    w_sub       = 4'(pcnt_q / PW'(SUB_DIV));
    w_cur       = digit_act_q[dig_q];
    w_seg       = raw_q ? w_cur : {w_cur[7], hex7(w_cur[3:0])};
    // sub-phase 0 stays dark so the digit switch never ghosts
    w_lit       = w_run && (w_sub != 4'd0) && (w_sub <= bright_q) &&
                  !blank_act_q[dig_q] && !w_blink_dark;
    w_frame_end = w_run && (pcnt_q == PCNT_LAST) && (dig_q == DIG_LAST);
  end

  // Control fields other than enable (enable lives in the FSM state)
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      raw_q    <= 1'b0;
      bright_q <= 4'hF;
    end else if (w_wr_ctrl) begin
      raw_q    <= wr_data[1];
      bright_q <= wr_data[7:4];
    end
  end

  // Shadow registers, frame-synchronous copy to active, pending flag
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      blank_sh_q  <= '0;
      blank_act_q <= '0;
      pending_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_sh_q[i]  <= 8'h00;
        digit_act_q[i] <= 8'h00;
      end
    end else begin
      if (w_wr_blank) blank_sh_q <= wr_data[NUM_DIGITS-1:0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_wr_digit[i]) digit_sh_q[i] <= wr_data[7:0];
      end
      // active copies the pre-write shadow, so a commit-cycle write waits a frame
      if (w_track || w_commit) begin
        blank_act_q <= blank_sh_q;
        for (int i = 0; i < NUM_DIGITS; i++) digit_act_q[i] <= digit_sh_q[i];
      end
      if (w_track)          pending_q <= 1'b0;
      else if (w_wr_shadow) pending_q <= 1'b1;
      else if (w_commit)    pending_q <= 1'b0;
    end
  end

  // Slot counter and digit index; cleared whenever the scan is not running
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || !w_run) begin
      pcnt_q <= '0;
      dig_q  <= '0;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_q <= '0;
      dig_q  <= (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // Registered pins: one clock behind the counters, polarity applied here
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      SMG_Data   <= SEG_OFF;
      Scan_Sig   <= SCAN_OFF;
      ft_q       <= 1'b0;
    end else begin
      SMG_Data   <= w_lit ? (w_seg ^ SEG_OFF) : SEG_OFF;
      Scan_Sig   <= w_lit ? ((NUM_DIGITS'(1) << dig_q) ^ SCAN_OFF) : SCAN_OFF;
      ft_q       <= w_frame_end;
    end
  end

  assign frame_tick = ft_q;

  // Read mux always reflects shadow state; unmapped addresses read zero
  always_comb begin
    w_rdata = '0;
    if (rd_addr == AW'(0)) w_rdata = {24'd0, bright_q, 2'b00, raw_q, state_q == ST_SCAN};
    if (rd_addr == AW'(1)) w_rdata[NUM_DIGITS-1:0] = blank_sh_q;
`ifdef SMG_BLINK_EN
    if (rd_addr == AW'(2)) w_rdata[NUM_DIGITS-1:0] = blink_sh_q;
`endif
    if (rd_addr == AW'(3)) w_rdata = {20'd0, 4'(dig_q), 7'd0, pending_q && (state_q == ST_SCAN)};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rd_addr == AW'(4 + i)) w_rdata[7:0] = digit_sh_q[i];
    end
  end

  // Read response register: data and valid one clock after the strobe
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_en ? w_rdata : 32'd0;
      rd_valid <= rd_en;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smg_scan_ctrl
//  Purpose  : Self-checking bench for smg_scan_ctrl (NUM_DIGITS=6, SUB_DIV=2)
//             with a frame-position reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smg_scan_ctrl;

  localparam int ND    = 6;
  localparam int SLOT  = 32;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid, frame_tick;
  logic [7:0]  SMG_Data;
  logic [5:0]  Scan_Sig;

  smg_scan_ctrl #(
    .NUM_DIGITS(ND), .SUB_DIV(2), .AW(5),
    .SEG_ACTIVE_LOW(1'b1), .SCAN_ACTIVE_LOW(1'b1), .BLINK_FRAMES(4)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic       m_en, m_raw, m_pend, m_ft;
  logic [3:0] m_bright;
  logic [5:0] m_bsh, m_bact;
  logic [7:0] m_dsh [ND];
  logic [7:0] m_dact [ND];
  int         m_t;   // position within the frame, cycles since digit 0 / pcnt 0
  logic [7:0]  exp_smg;
  logic [5:0]  exp_scan;
  logic        exp_ft, exp_rv;
  logic [31:0] exp_rd;

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return {24'd0, m_bright, 2'b00, m_raw, m_en};
    if (a == 5'd1) return {26'd0, m_bsh};
    if (a == 5'd3) return {20'd0, 4'(m_t / SLOT), 7'd0, m_pend && m_en};
    if (a >= 5'd4 && a < 5'd10) return {24'd0, m_dsh[a - 5'd4]};
    return 32'd0;
  endfunction

  task automatic model_step();
    logic en_next, run, lit, commit, track, sh_wr;
    int d, s;
    logic [7:0] cur, seg;
    logic [5:0] old_b;
    logic [7:0] old_d [ND];
    if (rst) begin
      m_en = 0; m_raw = 0; m_pend = 0; m_ft = 0; m_bright = 4'hF;
      m_bsh = 0; m_bact = 0; m_t = 0;
      for (int i = 0; i < ND; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
      exp_smg = 8'hFF; exp_scan = 6'h3F; exp_ft = 0; exp_rv = 0; exp_rd = 0;
      return;
    end
    en_next = (wr_en && wr_addr == 5'd0) ? wr_data[0] : m_en;
    run  = m_en && en_next;
    d    = m_t / SLOT;
    s    = (m_t % SLOT) / 2;
    cur  = m_dact[d];
    seg  = m_raw ? cur : {cur[7], HEX[cur[3:0]]};
    lit  = run && s >= 1 && s <= int'(m_bright) && !m_bact[d];
    exp_smg  = lit ? ~seg : 8'hFF;
    exp_scan = lit ? ~(6'd1 << d) : 6'h3F;
    exp_ft   = run && (m_t == FRAME - 1);
    exp_rv   = rd_en;
    exp_rd   = rd_en ? mread(rd_addr) : 32'd0;
    commit = m_ft && m_pend;
    track  = !m_en;
    old_b  = m_bsh;
    old_d  = m_dsh;
    sh_wr  = 0;
    if (wr_en) begin
      if (wr_addr == 5'd0) begin
        m_raw = wr_data[1]; m_bright = wr_data[7:4];
      end else if (wr_addr == 5'd1) begin
        m_bsh = wr_data[5:0]; sh_wr = 1;
      end else if (wr_addr >= 5'd4 && wr_addr < 5'd10) begin
        m_dsh[wr_addr - 5'd4] = wr_data[7:0]; sh_wr = 1;
      end
    end
    if (track || commit) begin m_bact = old_b; m_dact = old_d; end
    if (track)       m_pend = 0;
    else if (sh_wr)  m_pend = 1;
    else if (commit) m_pend = 0;
    m_t  = run ? (m_t + 1) % FRAME : 0;
    m_en = en_next;
    m_ft = exp_ft;
  endtask

  // one clock: model at the edge, compare pins on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("smg", SMG_Data, exp_smg);
    chk("scan", Scan_Sig, exp_scan);
    chk("frame_tick", frame_tick, exp_ft);
    chk("rd_valid", rd_valid, exp_rv);
    if (exp_rv) chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  // run to the next frame_tick, recording what a selected digit showed
  task automatic frame_capture(input logic [5:0] sel, output logic [7:0] seg,
                               output int n_sel, output int n_all, output int len);
    seg = 8'hFF; n_sel = 0; n_all = 0; len = 0;
    do begin
      cyc();
      len++;
      if (Scan_Sig == sel) begin n_sel++; seg = SMG_Data; end
      if (Scan_Sig != 6'h3F) n_all++;
    end while (frame_tick !== 1'b1 && len < 400);
    if (frame_tick !== 1'b1) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rv;
  logic [7:0]  sg;
  int          ns, na, ln, r;

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
    cyc(); cyc();
    rst = 1'b0;

    // reset defaults
    chk("rst_smg", SMG_Data, 8'hFF);
    chk("rst_scan", Scan_Sig, 6'h3F);
    rd(5'd0, rv); chk("rst_ctrl", rv, 32'hF0); chk("rst_rv", rd_valid, 1);
    rd(5'd4, rv); chk("rst_digit0", rv, 32'h0);

    // hex scan
    wr(5'd4, 32'h08); wr(5'd5, 32'h8A); wr(5'd0, 32'hF1);
    frame_capture(6'h3E, sg, ns, na, ln);
    frame_capture(6'h3E, sg, ns, na, ln);
    chk("hex_d0", sg, 8'h80); chk("ft_period", ln, FRAME); chk("d0_lit_f", ns, 30);
    frame_capture(6'h3D, sg, ns, na, ln);
    chk("hex_d1", sg, 8'h08);

    // brightness
    wr(5'd0, 32'h31);
    frame_capture(6'h3E, sg, ns, na, ln);
    frame_capture(6'h3E, sg, ns, na, ln);
    chk("bright3_slot", ns, 6); chk("bright3_frame", na, 36);
    wr(5'd0, 32'h01);
    frame_capture(6'h3E, sg, ns, na, ln);
    frame_capture(6'h3E, sg, ns, na, ln);
    chk("bright0_frame", na, 0);

    // double buffer
    wr(5'd0, 32'hF1);
    frame_capture(6'h3B, sg, ns, na, ln);
    repeat (20) cyc();
    wr(5'd6, 32'h05);
    rd(5'd3, rv); chk("pend_set", rv[0], 1);
    frame_capture(6'h3B, sg, ns, na, ln);
    chk("db_old", sg, 8'hC0);
    cyc();
    rd(5'd3, rv); chk("pend_clr", rv[0], 0);
    frame_capture(6'h3B, sg, ns, na, ln);
    chk("db_new", sg, 8'h92);
    repeat (20) cyc();
    wr(5'd6, 32'h06);
    frame_capture(6'h3B, sg, ns, na, ln);
    wr(5'd6, 32'h07);                       // lands on the commit cycle
    rd(5'd3, rv); chk("pend_keep", rv[0], 1);
    frame_capture(6'h3B, sg, ns, na, ln);
    chk("tick_wr_old", sg, 8'h82);
    frame_capture(6'h3B, sg, ns, na, ln);
    chk("tick_wr_new", sg, 8'hF8);

    // raw mode and blanking
    wr(5'd0, 32'hF3); wr(5'd7, 32'h80); wr(5'd1, 32'h08);
    frame_capture(6'h37, sg, ns, na, ln);
    frame_capture(6'h37, sg, ns, na, ln);
    chk("blank_d3", ns, 0);
    wr(5'd1, 32'h00);
    frame_capture(6'h37, sg, ns, na, ln);
    frame_capture(6'h37, sg, ns, na, ln);
    chk("raw_dp", sg, 8'h7F); chk("raw_d3_lit", ns, 30);

    // disable at pcnt 10, then re-enable
    repeat (10) cyc();
    chk("pre_dis_scan", Scan_Sig, 6'h3E);
    wr(5'd0, 32'hF2);
    chk("dis_scan", Scan_Sig, 6'h3F); chk("dis_smg", SMG_Data, 8'hFF);
    wr(5'd0, 32'hF3);
    cyc(); cyc();
    chk("reen_dark", Scan_Sig, 6'h3F);
    cyc();
    chk("reen_d0", Scan_Sig, 6'h3E);

    // reset mid-frame
    repeat (50) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_smg", SMG_Data, 8'hFF); chk("mid_rst_scan", Scan_Sig, 6'h3F);
    rd(5'd0, rv); chk("mid_rst_ctrl", rv, 32'hF0);
    rd(5'd7, rv); chk("mid_rst_d3", rv, 32'h0);

    // unmapped / blink-absent accesses
    wr(5'd20, 32'hFFFF_FFFF); rd(5'd20, rv); chk("unmapped", rv, 32'h0);
`ifndef SMG_BLINK_EN
    wr(5'd2, 32'hFFFF_FFFF); rd(5'd2, rv); chk("blink_absent", rv, 32'h0);
`endif

    // randomized traffic against the model
    wr(5'd0, 32'hF1);
    for (int k = 0; k < 5000; k++) begin
      r = $urandom_range(0, 999);
      if (r == 0) rst = 1'b1;
      if (r < 120) begin
        wr_en = 1'b1;
        wr_addr = 5'($urandom_range(0, 21));
`ifdef SMG_BLINK_EN
        if (wr_addr == 5'd2) wr_addr = 5'd1;
`endif
        wr_data = $urandom;
        if (wr_addr == 5'd0) wr_data[0] = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        rd_en = 1'b1; rd_addr = 5'($urandom_range(0, 31));
      end
      cyc();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
